// File: rtl/pwm_cmd_scheduler_if.sv
// Command packet bus into the PWM command scheduler: one cmd_valid strobe
// qualifies the whole packet for a single cycle.
interface pwm_cmd_scheduler_if #(
    parameter int _PAT_WIDTH = 16
);
    logic                  cmd_valid;
    logic [7:0]            cmd_func;
    logic [7:0]            cmd_ch;
    logic [7:0]            cmd_duty;
    logic [15:0]           cmd_dessert;
    logic [7:0]            cmd_num;
    logic [_PAT_WIDTH-1:0] cmd_pat;

    modport master (
        output cmd_valid, cmd_func, cmd_ch, cmd_duty, cmd_dessert, cmd_num, cmd_pat
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_ch, cmd_duty, cmd_dessert, cmd_num, cmd_pat
    );
endinterface

// File: rtl/pwm_cmd_scheduler.sv
// Queues start/stop commands and dispatches them strictly in order, one at a
// time, to a bank of PWM channels over a shared, otherwise-zero config bus.
module pwm_cmd_scheduler #(
    parameter int _NUM_CHANNELS = 4,
    parameter int _PAT_WIDTH    = 16,
    parameter int _FIFO_DEPTH   = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    pwm_cmd_scheduler_if.slave       cmd,
    input  logic [_NUM_CHANNELS-1:0] ch_busy,
    input  logic [_NUM_CHANNELS-1:0] ch_valid,
    output logic [_NUM_CHANNELS-1:0] ch_en,
    output logic [_NUM_CHANNELS-1:0] ch_stop,
    output logic [7:0]               ch_duty,
    output logic [15:0]              ch_dessert,
    output logic [7:0]               ch_num,
    output logic [_PAT_WIDTH-1:0]    ch_pat,
    output logic [_NUM_CHANNELS-1:0] ch_active,
    output logic                     fifo_full,
    output logic [7:0]               drop_cnt,
    output logic                     err_timeout
);
    localparam int CH_W = (_NUM_CHANNELS > 1) ? $clog2(_NUM_CHANNELS) : 1;
    localparam int AW   = (_FIFO_DEPTH > 1) ? $clog2(_FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(_FIFO_DEPTH + 1);

    localparam logic [7:0]    FUNC_START = 8'h01;
    localparam logic [7:0]    FUNC_STOP  = 8'h02;
    localparam logic [7:0]    NCH        = 8'(_NUM_CHANNELS);
    localparam logic [CW-1:0] DEPTH      = CW'(_FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(_FIFO_DEPTH - 1);
    // Last WAIT_ACK count before giving up: lands err_timeout 16 cycles after ch_en.
    localparam logic [3:0]    TMO_LAST   = 4'd14;

    typedef struct packed {
        logic                  is_stop;
        logic [CH_W-1:0]       ch;
        logic [7:0]            duty;
        logic [15:0]           dessert;
        logic [7:0]            num;
        logic [_PAT_WIDTH-1:0] pat;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK} state_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [_NUM_CHANNELS-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [_NUM_CHANNELS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    entry_t                   mem_q [_FIFO_DEPTH];
    entry_t                   head_q;
    entry_t                   push_entry;
    logic [AW-1:0]            wr_q, rd_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               drop_q;
    state_t                   state_q;
    logic [3:0]               tmo_q;
    logic [_NUM_CHANNELS-1:0] ch_en_q, ch_stop_q, ch_active_q, ch_active_d;
    logic [_NUM_CHANNELS-1:0] head_oh, act_set, act_clr;
    logic                     err_timeout_q;
    logic [7:0]               duty_q, num_q;
    logic [15:0]              dessert_q;
    logic [_PAT_WIDTH-1:0]    pat_q;
    logic                     func_ok, ch_ok, full, push, drop, pop;
    logic                     go_issue, do_stop, ack, do_tmo;

    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot.
    assign full     = (cnt_q == DEPTH);
    assign func_ok  = (cmd.cmd_func == FUNC_START) || (cmd.cmd_func == FUNC_STOP);
    assign ch_ok    = (cmd.cmd_ch < NCH);
    assign push     = cmd.cmd_valid && func_ok && ch_ok && !full;
    assign drop     = cmd.cmd_valid && !push;

    assign push_entry.is_stop = (cmd.cmd_func == FUNC_STOP);
    assign push_entry.ch      = cmd.cmd_ch[CH_W-1:0];
    assign push_entry.duty    = cmd.cmd_duty;
    assign push_entry.dessert = cmd.cmd_dessert;
    assign push_entry.num     = cmd.cmd_num;
    assign push_entry.pat     = cmd.cmd_pat;

    assign head_oh  = onehot(head_q.ch);
    assign do_stop  = (state_q == S_FETCH) && head_q.is_stop;
    assign go_issue = (state_q == S_FETCH) && !head_q.is_stop &&
                      !ch_busy[head_q.ch] && !ch_active_q[head_q.ch];
    assign ack      = (state_q == S_WAIT_ACK) && ch_busy[head_q.ch];
    assign do_tmo   = (state_q == S_WAIT_ACK) && !ack && (tmo_q == TMO_LAST);
    assign pop      = do_stop || (state_q == S_ISSUE);

    // Set is applied after clear so a same-cycle ch_valid cannot cancel a fresh start.
    assign act_set     = go_issue ? head_oh : '0;
    assign act_clr     = ch_valid | ((do_stop || do_tmo) ? head_oh : '0);
    assign ch_active_d = (ch_active_q & ~act_clr) | act_set;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_q] <= push_entry;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state_q == S_IDLE) begin
            head_q <= mem_q[rd_q];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
            ch_active_q <= '0;
        end else begin
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            if (drop) drop_q <= sat_inc(drop_q);
            cnt_q       <= cnt_d;
            ch_active_q <= ch_active_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            tmo_q         <= '0;
            ch_en_q       <= '0;
            ch_stop_q     <= '0;
            err_timeout_q <= 1'b0;
            duty_q        <= '0;
            dessert_q     <= '0;
            num_q         <= '0;
            pat_q         <= '0;
        end else begin
            ch_en_q       <= '0;
            ch_stop_q     <= '0;
            err_timeout_q <= 1'b0;
            duty_q        <= '0;
            dessert_q     <= '0;
            num_q         <= '0;
            pat_q         <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (do_stop) begin
                        ch_stop_q <= head_oh;
                        state_q   <= S_IDLE;
                    end else if (go_issue) begin
                        ch_en_q   <= head_oh;
                        duty_q    <= head_q.duty;
                        dessert_q <= head_q.dessert;
                        num_q     <= head_q.num;
                        pat_q     <= head_q.pat;
                        tmo_q     <= '0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack) begin
                        state_q <= S_IDLE;
                    end else if (do_tmo) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_en       = ch_en_q;
    assign ch_stop     = ch_stop_q;
    assign ch_duty     = duty_q;
    assign ch_dessert  = dessert_q;
    assign ch_num      = num_q;
    assign ch_pat      = pat_q;
    assign ch_active   = ch_active_q;
    assign fifo_full   = full;
    assign drop_cnt    = drop_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Bench for pwm_cmd_scheduler: directed scenarios plus randomised bursts, all
// scored against an in-order command queue model with a saturating drop count.
module tb_pwm_cmd_scheduler;
    localparam int NCH   = 4;
    localparam int PW    = 16;
    localparam int DEPTH = 4;

    typedef struct {
        bit              stop;
        int              ch;
        logic [7:0]      duty;
        logic [15:0]     dess;
        logic [7:0]      num;
        logic [PW-1:0]   pat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0] man_busy, resp_busy, man_valid, resp_valid;
    logic [NCH-1:0] ch_busy, ch_valid, ch_en, ch_stop, ch_active;
    logic [7:0]     ch_duty, ch_num, drop_cnt;
    logic [15:0]    ch_dessert;
    logic [PW-1:0]  ch_pat;
    logic           fifo_full, err_timeout;

    exp_t mq[$];
    int   m_drop;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   auto_resp = 1'b0;

    always #5 clk = ~clk;

    assign ch_busy  = man_busy | resp_busy;
    assign ch_valid = man_valid | resp_valid;

    pwm_cmd_scheduler_if #(._PAT_WIDTH(PW)) cif ();

    pwm_cmd_scheduler #(
        ._NUM_CHANNELS(NCH),
        ._PAT_WIDTH   (PW),
        ._FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .cmd        (cif),
        .ch_busy    (ch_busy),
        .ch_valid   (ch_valid),
        .ch_en      (ch_en),
        .ch_stop    (ch_stop),
        .ch_duty    (ch_duty),
        .ch_dessert (ch_dessert),
        .ch_num     (ch_num),
        .ch_pat     (ch_pat),
        .ch_active  (ch_active),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt),
        .err_timeout(err_timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] f, input logic [7:0] c, input logic [7:0] d,
                            input logic [15:0] ds, input logic [7:0] nm, input logic [PW-1:0] pt);
        exp_t e;
        cif.cmd_valid   = 1'b1;
        cif.cmd_func    = f;
        cif.cmd_ch      = c;
        cif.cmd_duty    = d;
        cif.cmd_dessert = ds;
        cif.cmd_num     = nm;
        cif.cmd_pat     = pt;
        if ((f == 8'h01 || f == 8'h02) && int'(c) < NCH && mq.size() < DEPTH) begin
            e.stop = (f == 8'h02);
            e.ch   = int'(c);
            e.duty = d;
            e.dess = ds;
            e.num  = nm;
            e.pat  = pt;
            mq.push_back(e);
        end else if (m_drop < 255) begin
            m_drop++;
        end
        tick();
        cif.cmd_valid   = 1'b0;
        cif.cmd_func    = '0;
        cif.cmd_ch      = '0;
        cif.cmd_duty    = '0;
        cif.cmd_dessert = '0;
        cif.cmd_num     = '0;
        cif.cmd_pat     = '0;
    endtask

    task automatic do_reset();
        auto_resp     = 1'b0;
        man_busy      = '0;
        man_valid     = '0;
        cif.cmd_valid = 1'b0;
        rst_n         = 1'b0;
        mq.delete();
        m_drop = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"},     64'(ch_en), 64'(0));
        check_eq({tag, "_stop"},   64'(ch_stop), 64'(0));
        check_eq({tag, "_active"}, 64'(ch_active), 64'(0));
        check_eq({tag, "_err"},    64'(err_timeout), 64'(0));
        check_eq({tag, "_full"},   64'(fifo_full), 64'(0));
        check_eq({tag, "_drop"},   64'(drop_cnt), 64'(0));
        check_eq({tag, "_bus"},    64'({ch_duty, ch_dessert, ch_num, ch_pat}), 64'(0));
    endtask

    // Compares the current cycle's dispatch against the oldest queued command.
    task automatic check_issue_now();
        exp_t           e;
        logic [NCH-1:0] one, v;
        if (mq.size() == 0) begin
            check_eq("unexpected_issue", 64'({ch_en, ch_stop}), 64'(0));
            return;
        end
        e   = mq.pop_front();
        one = 1;
        v   = one << e.ch;
        if (e.stop) begin
            check_eq("stop_vec",    64'(ch_stop), 64'(v));
            check_eq("stop_no_en",  64'(ch_en), 64'(0));
            check_eq("stop_active", 64'(ch_active[e.ch]), 64'(0));
        end else begin
            check_eq("en_vec",      64'(ch_en), 64'(v));
            check_eq("en_no_stop",  64'(ch_stop), 64'(0));
            check_eq("bus_duty",    64'(ch_duty), 64'(e.duty));
            check_eq("bus_dessert", 64'(ch_dessert), 64'(e.dess));
            check_eq("bus_num",     64'(ch_num), 64'(e.num));
            check_eq("bus_pat",     64'(ch_pat), 64'(e.pat));
            check_eq("active_set",  64'(ch_active[e.ch]), 64'(1));
        end
    endtask

    task automatic wait_issue(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((ch_en | ch_stop) == '0 && n < budget);
        if ((ch_en | ch_stop) == '0) begin
            check_eq("issue_wait_cycles", 64'(n), 64'(budget - 1));
            if (mq.size() > 0) void'(mq.pop_front());
        end else begin
            check_issue_now();
        end
    endtask

    // Channel model: acknowledges each ch_en with a short busy burst, then a done pulse.
    initial begin
        int hold [NCH];
        resp_busy  = '0;
        resp_valid = '0;
        forever begin
            @(negedge clk);
            resp_valid = '0;
            if (!auto_resp) begin
                resp_busy = '0;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (ch_en[k]) begin
                        resp_busy[k] = 1'b1;
                        hold[k]      = int'($urandom_range(1, 4));
                    end else if (resp_busy[k]) begin
                        hold[k]--;
                        if (hold[k] <= 0) begin
                            resp_busy[k]  = 1'b0;
                            resp_valid[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_eq("en_onehot",   64'($onehot0(ch_en)), 64'(1));
            check_eq("stop_onehot", 64'($onehot0(ch_stop)), 64'(1));
            if (ch_en == '0)
                check_eq("bus_idle", 64'({ch_duty, ch_dessert, ch_num, ch_pat}), 64'(0));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] acc;
        logic [7:0]     f, c, d, nm;
        logic [15:0]    ds;
        logic [PW-1:0]  pt;
        int             k, sel;

        rst_n = 1'b0;
        man_busy = '0;
        man_valid = '0;
        cif.cmd_valid = 1'b0;
        do_reset();
        check_all_zero("reset");

        // Single start with exact 3-cycle latency; first pass uses the fixed packet.
        for (int it = 0; it < 3; it++) begin
            c  = (it == 0) ? 8'd1 : 8'($urandom_range(0, NCH - 1));
            d  = (it == 0) ? 8'h10 : 8'($urandom);
            ds = (it == 0) ? 16'h0020 : 16'($urandom);
            nm = (it == 0) ? 8'd3 : 8'($urandom);
            pt = (it == 0) ? 16'hA5A5 : PW'($urandom);
            send_cmd(8'h01, c, d, ds, nm, pt);
            check_eq("lat_c1", 64'(ch_en), 64'(0));
            tick();
            check_eq("lat_c2", 64'(ch_en), 64'(0));
            tick();
            check_issue_now();
            tick();
            man_busy[c] = 1'b1;
            repeat (3) tick();
            check_eq("active_hold", 64'(ch_active[c]), 64'(1));
            man_busy[c]  = 1'b0;
            man_valid[c] = 1'b1;
            tick();
            man_valid[c] = 1'b0;
            check_eq("active_clr", 64'(ch_active[c]), 64'(0));
            tick();
        end

        // Stop issued to a channel that is still busy.
        do_reset();
        send_cmd(8'h01, 8'd2, 8'h33, 16'h0100, 8'd0, PW'(16'h1234));
        tick();
        tick();
        check_issue_now();
        man_busy[2] = 1'b1;
        repeat (4) tick();
        send_cmd(8'h02, 8'd2, 8'h00, 16'h0000, 8'h00, '0);
        tick();
        tick();
        check_issue_now();
        man_busy[2] = 1'b0;

        // Overflow behind a busy channel.
        do_reset();
        man_busy = 4'b0001;
        for (int i = 0; i < 6; i++) send_cmd(8'h01, 8'd0, 8'(i), 16'(i), 8'(i), PW'(i));
        check_eq("ovf_full", 64'(fifo_full), 64'(1));
        check_eq("ovf_drop", 64'(drop_cnt), 64'(2));
        check_eq("ovf_model_q", 64'(mq.size()), 64'(DEPTH));
        check_eq("ovf_no_en", 64'(ch_en), 64'(0));

        // Invalid channel and invalid function.
        do_reset();
        send_cmd(8'h01, 8'd7, 8'h11, 16'h2222, 8'h33, PW'(16'h4444));
        check_eq("inv_ch_drop", 64'(drop_cnt), 64'(m_drop));
        send_cmd(8'h05, 8'd0, 8'h11, 16'h2222, 8'h33, PW'(16'h4444));
        check_eq("inv_func_drop", 64'(drop_cnt), 64'(m_drop));
        acc = '0;
        repeat (8) begin
            tick();
            acc = acc | ch_en | ch_stop;
        end
        check_eq("inv_no_issue", 64'(acc), 64'(0));
        check_eq("inv_not_full", 64'(fifo_full), 64'(0));

        // Head-of-line blocking.
        do_reset();
        man_busy = 4'b0001;
        send_cmd(8'h01, 8'd0, 8'hA0, 16'h00A0, 8'd1, PW'(16'h00A0));
        send_cmd(8'h01, 8'd2, 8'hB2, 16'h00B2, 8'd2, PW'(16'h00B2));
        acc = '0;
        repeat (12) begin
            tick();
            acc = acc | ch_en;
        end
        check_eq("hol_blocked", 64'(acc), 64'(0));
        man_busy  = '0;
        auto_resp = 1'b1;
        wait_issue(20);
        wait_issue(20);

        // Start timeout.
        do_reset();
        send_cmd(8'h01, 8'd3, 8'h01, 16'h0002, 8'h03, PW'(16'h0004));
        tick();
        tick();
        check_issue_now();
        acc = '0;
        repeat (15) begin
            tick();
            acc[0] = acc[0] | err_timeout;
        end
        check_eq("tmo_early", 64'(acc), 64'(0));
        tick();
        check_eq("tmo_pulse", 64'(err_timeout), 64'(1));
        check_eq("tmo_active", 64'(ch_active[3]), 64'(0));
        tick();
        check_eq("tmo_one_cycle", 64'(err_timeout), 64'(0));

        // Reset while waiting for ack with two commands still queued.
        do_reset();
        send_cmd(8'h01, 8'd1, 8'h10, 16'h0010, 8'h01, PW'(16'h0101));
        send_cmd(8'h01, 8'd2, 8'h20, 16'h0020, 8'h02, PW'(16'h0202));
        send_cmd(8'h01, 8'd1, 8'h30, 16'h0030, 8'h03, PW'(16'h0303));
        check_issue_now();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        do_reset();
        acc = '0;
        repeat (30) begin
            tick();
            acc = acc | ch_en | ch_stop;
        end
        check_eq("no_replay", 64'(acc), 64'(0));

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            send_cmd(8'h00, 8'($urandom_range(0, 9)), 8'h00, 16'h0000, 8'h00, '0);
            if (i == 199) check_eq("drop_200", 64'(drop_cnt), 64'(m_drop));
        end
        check_eq("drop_sat", 64'(drop_cnt), 64'(m_drop));

        // Randomised bursts behind busy channels, then an in-order drain.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            man_busy = '1;
            k = int'($urandom_range(3, 9));
            for (int i = 0; i < k; i++) begin
                sel = int'($urandom_range(0, 9));
                f   = (sel < 6) ? 8'h01 : (sel == 6) ? 8'h03 : (sel == 7) ? 8'h00 : 8'h05;
                send_cmd(f, 8'($urandom_range(0, 5)), 8'($urandom), 16'($urandom),
                         8'($urandom), PW'($urandom));
            end
            check_eq("rnd_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
            check_eq("rnd_drop", 64'(drop_cnt), 64'(m_drop));
            man_busy  = '0;
            auto_resp = 1'b1;
            while (mq.size() > 0) wait_issue(80);
            acc = '0;
            repeat (15) begin
                tick();
                acc = acc | ch_en | ch_stop;
            end
            check_eq("rnd_no_extra", 64'(acc), 64'(0));
            check_eq("rnd_active_idle", 64'(ch_active), 64'(0));
            check_eq("rnd_empty", 64'(fifo_full), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_cmd_scheduler.md
PWM_CMD_SCHEDULER -- requirements
Module: pwm_cmd_scheduler

Interface
REQ-001 SHALL have parameter _NUM_CHANNELS, default 4: number of PWM channels served (1..8).
REQ-002 SHALL have parameter _PAT_WIDTH, default 16: pattern register width.
REQ-003 SHALL have parameter _FIFO_DEPTH, default 4: command queue depth (power of 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- sys_clk  in  1  clock
- sys_rst_n  in  1  async active-low reset
REQ-005 SHALL have the following command ports:
- cmd_valid  in  1  one-cycle packet-done strobe
- cmd_func  in  8  0x01=start, 0x02=stop, other=drop
- cmd_ch  in  8  target channel index
- cmd_duty  in  8  duty cycles
- cmd_dessert  in  16  pulse gap cycles
- cmd_num  in  8  pulse count, 0=infinite
- cmd_pat  in  _PAT_WIDTH  pattern
REQ-006 SHALL have the following channel ports:
- ch_busy  in  _NUM_CHANNELS  per-channel busy level
- ch_valid  in  _NUM_CHANNELS  per-channel one-cycle done pulse
- ch_en  out  _NUM_CHANNELS  one-hot one-cycle start pulse
- ch_stop  out  _NUM_CHANNELS  one-hot one-cycle stop pulse
- ch_duty / ch_dessert / ch_num / ch_pat  out  8/16/8/_PAT_WIDTH  shared config bus; valid only in the ch_en cycle
REQ-007 SHALL have the following status ports:
- ch_active  out  _NUM_CHANNELS  channel owned by scheduler
- fifo_full  out  1  queue full
- drop_cnt  out  8  dropped-command count
- err_timeout  out  1  one-cycle start-timeout pulse

Function
REQ-008 SHALL push {func, ch, duty, dessert, num, pat} into the FIFO on cmd_valid when the FIFO is not full and cmd_ch < _NUM_CHANNELS.
REQ-009 SHALL drop a command, without pushing it, when cmd_valid arrives with the FIFO full, cmd_ch >= _NUM_CHANNELS, or cmd_func not in {0x01, 0x02}.
REQ-010 SHALL increment drop_cnt by 1 for each dropped command and saturate it at 255.
REQ-011 SHALL evaluate fullness before any same-cycle pop, so a push arriving while the FIFO is full is dropped even if a pop occurs in that cycle.
REQ-012 SHALL implement FSM states IDLE, FETCH, ISSUE and WAIT_ACK.
REQ-013 SHALL, in IDLE, register the FIFO head and go to FETCH when the FIFO is non-empty.
REQ-014 SHALL, in FETCH for a stop command, pulse ch_stop[ch], clear ch_active[ch], pop the FIFO and return to IDLE.
REQ-015 SHALL, in FETCH for a start command, go to ISSUE when ch_busy[ch]=0 and ch_active[ch]=0, and otherwise stay in FETCH (head-of-line blocking, no reordering).
REQ-016 SHALL, in ISSUE, drive the config bus, pulse ch_en[ch] for one cycle, set ch_active[ch], pop the FIFO and go to WAIT_ACK.
REQ-017 SHALL, in WAIT_ACK, return to IDLE as soon as ch_busy[ch]=1.
REQ-018 SHALL, if ch_busy[ch] is not seen within 16 cycles of the ch_en pulse, pulse err_timeout, clear ch_active[ch] and return to IDLE.
REQ-019 SHALL clear ch_active[i] on ch_valid[i]; when a set and a clear hit the same channel in the same cycle, the set wins.
REQ-020 SHALL assert ch_en exactly 3 cycles after cmd_valid when the FIFO is empty and the target channel is idle (cmd_valid at cycle 0, ch_en at cycle 3).
REQ-021 SHALL hold the config bus at zero outside the ch_en cycle.
REQ-022 SHALL never assert more than one ch_en or ch_stop bit in the same cycle.
REQ-023 SHALL wrap the FIFO pointers modulo _FIFO_DEPTH and assert fifo_full when count == _FIFO_DEPTH.

Reset
REQ-024 SHALL, on sys_rst_n low at any time including mid-command, immediately force:
- FSM to IDLE
- FIFO empty
- ch_en, ch_stop, ch_active, err_timeout and config bus to 0
- fifo_full = 0, drop_cnt = 0
REQ-025 SHALL NOT replay queued commands after reset release.

Verification
REQ-026 SHALL cover single start: start ch1, duty=8'h10, dessert=16'h0020, num=3, pat=16'hA5A5, channel idle -> ch_en=4'b0010 at cycle 3 with the bus carrying those values; ch_active[1]=1 until ch_valid[1].
REQ-027 SHALL cover overflow: 6 back-to-back starts to busy ch0 with depth 4 -> 4 queued, fifo_full=1, drop_cnt=2.
REQ-028 SHALL cover invalid commands: cmd_ch=7 with N=4, and cmd_func=0x05 -> neither queued, drop_cnt increments by 1 each.
REQ-029 SHALL cover head-of-line blocking: ch0 busy with ch0 start queued ahead of a ch2 start -> no ch_en[2] until ch_busy[0] falls; then ch_en[0] precedes ch_en[2].
REQ-030 SHALL cover timeout: start ch3 with ch_busy held 0 -> err_timeout pulse 16 cycles after ch_en, ch_active[3]=0.
REQ-031 SHALL cover reset mid-operation: assert sys_rst_n=0 while in WAIT_ACK with 2 commands queued -> all outputs 0, and no ch_en after release.
